// File: rtl/decimator_pkg.sv
// Shared types and helpers for the decimate-by-2 polyphase FIR.
// Optional feature macro: DECIMATOR_FLUSH_EN (adds flush_in to the block).
package decimator_pkg;

    // Commutator phase: PHASE0 expects the even sample, PHASE1 the odd one.
    typedef enum logic {
        PHASE0 = 1'b0,
        PHASE1 = 1'b1
    } phase_e;

    // Full-precision output width: product width plus growth for N taps.
    function automatic int out_width(input int dw, input int cw, input int n);
        return dw + cw + $clog2(n);
    endfunction

endpackage

// File: rtl/decimator_ctrl.sv
// Control for the decimator: commutator phase FSM, pending-result flag,
// output-valid flag and the load / shift / ready strobes for the datapath.
// Optional feature macro: DECIMATOR_FLUSH_EN (adds flush_in).
module decimator_ctrl
    import decimator_pkg::*;
(
    input  logic clk,
    input  logic arst_n,
`ifdef DECIMATOR_FLUSH_EN
    input  logic flush_in,
`endif
    input  logic bypass,
    input  logic src_valid_in,
    input  logic dst_ready_in,
    output logic src_ready,
    output logic out_valid,
    output logic shift_e,
    output logic shift_o,
    output logic load
);

    phase_e r_phase;
    phase_e w_phase_nxt;
    logic   r_pending;
    logic   w_pending_nxt;
    logic   r_out_valid;
    logic   w_out_valid_nxt;
    logic   w_accept;
    logic   w_flush;

`ifdef DECIMATOR_FLUSH_EN
    assign w_flush = flush_in;
`else
    assign w_flush = 1'b0;
`endif

    // Strobes and next state; a flush blocks every transfer in its cycle.
    always_comb begin
        w_phase_nxt     = r_phase;
        w_pending_nxt   = r_pending;
        w_out_valid_nxt = r_out_valid;

        load      = r_pending && (!r_out_valid || dst_ready_in) && !bypass && !w_flush;
        src_ready = (!r_pending || load) && !w_flush;
        out_valid = r_out_valid && !w_flush;
        w_accept  = src_valid_in && src_ready && !bypass;
        shift_e   = w_accept && (r_phase == PHASE0);
        shift_o   = w_accept && (r_phase == PHASE1);

        if (w_accept)
            w_phase_nxt = (r_phase == PHASE0) ? PHASE1 : PHASE0;

        // A freshly accepted odd sample keeps the flag set through a load.
        if (shift_o)
            w_pending_nxt = 1'b1;
        else if (load)
            w_pending_nxt = 1'b0;

        if (load)
            w_out_valid_nxt = 1'b1;
        else if (out_valid && dst_ready_in)
            w_out_valid_nxt = 1'b0;
    end

    // State register; flush acts like reset one level below arst_n.
    always_ff @(posedge clk) begin
        if (!arst_n || w_flush) begin
            r_phase     <= PHASE0;
            r_pending   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_phase     <= w_phase_nxt;
            r_pending   <= w_pending_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

endmodule

// File: rtl/decimator.sv
// Decimate-by-2 polyphase FIR with valid/ready streams and a bypass path.
// Even samples feed line E (taps h[1],h[3],..), odd samples feed line O
// (taps h[0],h[2],..); each completed pair yields one full-precision output.
// Optional feature macro: DECIMATOR_FLUSH_EN (adds flush_in).
module decimator
    import decimator_pkg::*;
#(
    parameter  int DATA_WIDTH   = 16,
    parameter  int COEFF_WIDTH  = 16,
    parameter  int N_COEFFS     = 40,
    localparam int OUTPUT_WIDTH = out_width(DATA_WIDTH, COEFF_WIDTH, N_COEFFS)
) (
    input  logic                                  clk,
    input  logic                                  arst_n,
`ifdef DECIMATOR_FLUSH_EN
    input  logic                                  flush_in,
`endif
    input  logic                                  bypass,
    input  logic [N_COEFFS-1:0][COEFF_WIDTH-1:0]  coeffs,
    input  logic [DATA_WIDTH-1:0]                 src_data_in,
    input  logic                                  src_valid_in,
    output logic                                  src_ready_out,
    output logic [OUTPUT_WIDTH-1:0]               dst_data_out,
    output logic                                  dst_valid_out,
    input  logic                                  dst_ready_in
);

    localparam int NT = N_COEFFS / 2;
    localparam int PW = DATA_WIDTH + COEFF_WIDTH;

    logic [NT-1:0][DATA_WIDTH-1:0]  r_even;
    logic [NT-1:0][DATA_WIDTH-1:0]  r_odd;
    logic signed [OUTPUT_WIDTH-1:0] r_out;
    logic signed [OUTPUT_WIDTH-1:0] w_sum;
    logic signed [OUTPUT_WIDTH-1:0] w_byp;
    logic signed [PW-1:0]           w_prod_o;
    logic signed [PW-1:0]           w_prod_e;
    logic                           w_src_ready;
    logic                           w_out_valid;
    logic                           w_shift_e;
    logic                           w_shift_o;
    logic                           w_load;
    logic                           w_flush;

`ifdef DECIMATOR_FLUSH_EN
    assign w_flush = flush_in;
`else
    assign w_flush = 1'b0;
`endif

    decimator_ctrl u_ctrl (
        .clk          (clk),
`ifdef DECIMATOR_FLUSH_EN
        .flush_in     (flush_in),
`endif
        .arst_n       (arst_n),
        .bypass       (bypass),
        .src_valid_in (src_valid_in),
        .dst_ready_in (dst_ready_in),
        .src_ready    (w_src_ready),
        .out_valid    (w_out_valid),
        .shift_e      (w_shift_e),
        .shift_o      (w_shift_o),
        .load         (w_load)
    );

    // MAC over both phases; operands widened first so products are exact.
    always_comb begin
        w_sum    = '0;
        w_prod_o = '0;
        w_prod_e = '0;
        for (int j = 0; j < NT; j++) begin
            w_prod_o = PW'($signed(r_odd[j]))  * PW'($signed(coeffs[2*j]));
            w_prod_e = PW'($signed(r_even[j])) * PW'($signed(coeffs[2*j+1]));
            w_sum    = w_sum + OUTPUT_WIDTH'(w_prod_o) + OUTPUT_WIDTH'(w_prod_e);
        end
    end

    // Delay lines: the commutator routes each accepted sample to one line.
    always_ff @(posedge clk) begin
        if (!arst_n || w_flush) begin
            r_even <= '0;
            r_odd  <= '0;
        end else begin
            if (w_shift_e) begin
                r_even[0] <= src_data_in;
                for (int j = 1; j < NT; j++)
                    r_even[j] <= r_even[j-1];
            end
            if (w_shift_o) begin
                r_odd[0] <= src_data_in;
                for (int j = 1; j < NT; j++)
                    r_odd[j] <= r_odd[j-1];
            end
        end
    end

    // Output register captures the sum of the pre-edge line contents.
    always_ff @(posedge clk) begin
        if (!arst_n || w_flush)
            r_out <= '0;
        else if (w_load)
            r_out <= w_sum;
    end

    // Bypass scales input to the same Q position as a unity-gain tap.
    assign w_byp = OUTPUT_WIDTH'($signed(src_data_in)) <<< (COEFF_WIDTH - 1);

    // Output mux: bypass is a pure combinational pass-through.
    always_comb begin
        dst_data_out  = r_out;
        dst_valid_out = w_out_valid;
        src_ready_out = w_src_ready;
        if (bypass) begin
            dst_data_out  = w_byp;
            dst_valid_out = src_valid_in && !w_flush;
            src_ready_out = dst_ready_in && !w_flush;
        end
    end

endmodule

// File: tb/tb_decimator.sv
// Self-checking bench for decimator (N_COEFFS=4): directed cases plus a
// randomized run scored against a sum-of-products reference on a sample log.
module tb_decimator;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int NC = 4;
    localparam int OW = DW + CW + $clog2(NC);

    logic                   clk = 1'b0;
    logic                   arst_n;
    logic                   bypass;
    logic [NC-1:0][CW-1:0]  coeffs;
    logic [DW-1:0]          src_data_in;
    logic                   src_valid_in;
    logic                   src_ready_out;
    logic [OW-1:0]          dst_data_out;
    logic                   dst_valid_out;
    logic                   dst_ready_in;

    decimator #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .N_COEFFS(NC)) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .bypass        (bypass),
        .coeffs        (coeffs),
        .src_data_in   (src_data_in),
        .src_valid_in  (src_valid_in),
        .src_ready_out (src_ready_out),
        .dst_data_out  (dst_data_out),
        .dst_valid_out (dst_valid_out),
        .dst_ready_in  (dst_ready_in)
    );

    always #5 clk = ~clk;

    int       n_cmp = 0;
    int       n_err = 0;
    longint   h[NC];
    longint   xs[$];
    longint   obs[$];
    int       m = 0;
    int       cyc = 0;
    int       first_v_cyc = -1;
    logic     s_r, s_v, in_xfer, hold_pend;
    longint   s_d, hold_d;
    int       last_send_ticks;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // y[mm] = sum_k h[k] * x[2mm+1-k], x[n<0] = 0
    function automatic longint ref_y(input int mm);
        longint s = 0;
        for (int k = 0; k < NC; k++) begin
            int idx = 2*mm + 1 - k;
            if (idx >= 0) s += h[k] * xs[idx];
        end
        return s;
    endfunction

    function automatic longint obs_at(input int i);
        return (i < obs.size()) ? obs[i] : -999;
    endfunction

    task automatic set_coeffs();
        for (int k = 0; k < NC; k++) coeffs[k] = h[k][15:0];
    endtask

    // One clock: sample outputs, score transfers, advance to next negedge.
    task automatic tick();
        #1;
        s_r = src_ready_out;
        s_v = dst_valid_out;
        s_d = longint'($signed(dst_data_out));
        in_xfer = 1'b0;
        if (arst_n && !bypass) begin
            if (hold_pend) begin
                chk("hold_valid", longint'(s_v), 1);
                chk("hold_data", s_d, hold_d);
            end
            if (s_v && first_v_cyc < 0) first_v_cyc = cyc;
            if (s_v && dst_ready_in) begin
                if (2*m + 1 < xs.size())
                    chk($sformatf("y%0d", m), s_d, ref_y(m));
                else
                    chk("spurious_out", longint'(xs.size()), longint'(2*m + 2));
                obs.push_back(s_d);
                m++;
            end
            if (src_valid_in && s_r) begin
                xs.push_back(longint'($signed(src_data_in)));
                in_xfer = 1'b1;
            end
            hold_pend = s_v && !dst_ready_in;
            hold_d    = s_d;
        end else begin
            hold_pend = 1'b0;
        end
        @(posedge clk);
        if (!arst_n) begin
            xs.delete();
            m = 0;
            hold_pend = 1'b0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [DW-1:0] x);
        int t = 0;
        src_valid_in = 1'b1;
        src_data_in  = x;
        do begin
            tick();
            t++;
        end while (!in_xfer && t < 100);
        if (!in_xfer) chk("send_timeout", longint'(t), 0);
        last_send_ticks = t;
        src_valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        src_valid_in = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        src_valid_in = 1'b0;
        tick();
        tick();
        arst_n = 1'b1;
        obs.delete();
        first_v_cyc = -1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int acc_c;
        int drops;
        logic [15:0] rv;

        arst_n = 1'b0; bypass = 1'b0; src_data_in = '0;
        src_valid_in = 1'b0; dst_ready_in = 1'b1; hold_pend = 1'b0;
        h = '{1, 2, 3, 4};
        set_coeffs();

        // Reset then idle
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_valid", longint'(s_v), 0);
            chk("rst_data", s_d, 0);
            chk("rst_ready", longint'(s_r), 1);
        end

        // Back-to-back 1,2,3,4 -> 4, 20
        do_reset();
        drops = 0; acc_c = -100;
        for (int i = 1; i <= 4; i++) begin
            send(DW'(i));
            if (i == 2) acc_c = cyc - 1;
            drops += last_send_ticks - 1;
        end
        idle(4);
        chk("b2b_ready_drops", longint'(drops), 0);
        chk("b2b_latency", longint'(first_v_cyc - acc_c), 2);
        chk("b2b_count", longint'(obs.size()), 2);
        chk("b2b_y0", obs_at(0), 4);
        chk("b2b_y1", obs_at(1), 20);

        // Impulse 0,1,0,0,0,0 -> 1, 3, 0
        do_reset();
        send(16'd0); send(16'd1);
        for (int i = 0; i < 4; i++) send(16'd0);
        idle(4);
        chk("imp_count", longint'(obs.size()), 3);
        chk("imp_y0", obs_at(0), 1);
        chk("imp_y1", obs_at(1), 3);
        chk("imp_y2", obs_at(2), 0);

        // Backpressure: sink stalled for 6 cycles, source always valid
        do_reset();
        dst_ready_in = 1'b0;
        src_valid_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            src_data_in = DW'($urandom);
            tick();
        end
        chk("bp_accepted", longint'(xs.size()), 4);
        chk("bp_ready_low", longint'(s_r), 0);
        chk("bp_valid_held", longint'(s_v), 1);
        dst_ready_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            src_data_in = DW'($urandom);
            tick();
        end
        idle(6);
        chk("bp_all_out", longint'(obs.size()), longint'(xs.size() / 2));

        // Reset after an odd sample, before its result appears
        do_reset();
        send(16'd11); send(16'd13);
        arst_n = 1'b0;
        tick();
        arst_n = 1'b1;
        obs.delete();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_mid_no_out", longint'(s_v), 0);
        end
        send(16'd5); send(16'd7);
        idle(4);
        chk("rst_mid_count", longint'(obs.size()), 1);
        chk("rst_mid_y", obs_at(0), 17);

        // Bypass: combinational pass-through, state frozen
        bypass = 1'b1;
        src_data_in = 16'h8001;
        for (int i = 0; i < 4; i++) begin
            src_valid_in = i[0];
            dst_ready_in = i[1];
            tick();
            chk("byp_data", s_d, longint'(-32767) * 32768);
            chk("byp_valid", longint'(s_v), longint'(i[0]));
            chk("byp_ready", longint'(s_r), longint'(i[1]));
        end
        bypass = 1'b0;
        src_valid_in = 1'b0;
        dst_ready_in = 1'b1;
        tick();
        send(16'd1); send(16'd2);
        idle(4);
        chk("post_byp_y", obs_at(1), 45);

        // Randomized traffic with random signed taps
        for (int k = 0; k < NC; k++) begin
            rv = 16'($urandom);
            h[k] = longint'($signed(rv));
        end
        set_coeffs();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            src_valid_in = ($urandom % 4) != 0;
            src_data_in  = DW'($urandom);
            dst_ready_in = ($urandom % 3) != 0;
            tick();
        end
        dst_ready_in = 1'b1;
        idle(8);
        chk("rand_drain", longint'(m), longint'(xs.size() / 2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decimator.md
Name: decimator

Overview:
Configurable-bypass, decimate-by-2 polyphase FIR and the receive-side counterpart of the rate-2 interpolator. A commutator splits the input stream into even and odd phases, each feeding its own delay line. On every completed even/odd sample pair, the block produces one full-precision filtered output. Valid/ready streaming interfaces on both sides, with the same bypass semantics as the interpolator.

Parameters:
DATA_WIDTH, 16, signed input sample width
COEFF_WIDTH, 16, signed coefficient width
N_COEFFS, 40, total prototype taps; must be even; N_COEFFS/2 taps per phase
OUTPUT_WIDTH (localparam), DATA_WIDTH+COEFF_WIDTH+$clog2(N_COEFFS), full-precision output width

Ports:
clk  in  1  clock
arst_n  in  1  reset, synchronous, active-low
bypass  in  1  1 = pass input straight through, no decimation
coeffs  in  N_COEFFS x COEFF_WIDTH  signed taps; coeffs[k] = h[k]; static during operation
src_data_in  in  DATA_WIDTH  signed input sample
src_valid_in  in  1  input valid
src_ready_out  out  1  input ready
dst_data_out  out  OUTPUT_WIDTH  signed output sample
dst_valid_out  out  1  output valid
dst_ready_in  in  1  output ready

Behaviour:
- Reset (arst_n=0 at a clk edge): phase=PHASE0, pending=0, both delay lines 0, out register 0, out_valid=0.
  - Outputs after reset: dst_valid_out=0, dst_data_out=0, src_ready_out=1 (bypass=0).
  - Reset applied mid-operation discards any in-flight sample or result.
- Transfer rule: a transfer occurs in any cycle where valid&&ready on that interface.
- Transfer function: y[m] = sum_{k=0}^{N-1} h[k]*x[2m+1-k], with x[n<0]=0.
  - x[0] is the first sample accepted after reset.
  - Odd line O holds x[2m+1], x[2m-1], ... and is weighted by h[0], h[2], ...
  - Even line E holds x[2m], x[2m-2], ... and is weighted by h[1], h[3], ...
- Commutator FSM:
  - PHASE0: accepted sample shifts into E; go to PHASE1.
  - PHASE1: accepted sample shifts into O; set pending; go to PHASE0.
  - No transfer: state holds.
- Output load: load = pending && (!out_valid || dst_ready_in).
  - On load, the out register captures the MAC sum of the current lines (pre-edge values) and out_valid is set.
  - pending clears on load, unless a new odd sample is accepted in the same cycle.
- src_ready_out = !pending || load.
  - An even sample may be accepted in the same cycle a pending result loads; full 1 sample/cycle input rate is sustained.
- Latency: odd sample accepted in cycle c -> dst_valid_out=1 in cycle c+2 at earliest.
- Output handshake:
  - dst_data_out is stable while dst_valid_out=1 and dst_ready_in=0.
  - out_valid clears on transfer unless a load occurs in the same cycle.
- Arithmetic: signed products are DATA_WIDTH+COEFF_WIDTH wide, summed at OUTPUT_WIDTH. No rounding, no truncation, no overflow possible.
- Bypass=1:
  - dst_data_out = src_data_in sign-extended to OUTPUT_WIDTH after shifting left by COEFF_WIDTH-1.
  - dst_valid_out=src_valid_in, src_ready_out=dst_ready_in.
  - Internal state is frozen: no shifts, no loads.
  - bypass may change only when pending=0 and out_valid=0; behaviour is undefined otherwise.

Optional Feature:
- Macro DECIMATOR_FLUSH_EN.
- Defined:
  - Adds input port flush_in (1 bit).
  - flush_in=1 at a clk edge behaves as reset: clears both lines, pending and out_valid, and sets phase=PHASE0.
  - No transfer completes in the flush cycle.
  - flush_in has priority below arst_n.
- Undefined: no port; the phase can only be realigned by reset.

Decomposition:
- Package decimator_pkg: enum phase_e {PHASE0, PHASE1}; function out_width(dw, cw, n) returning the OUTPUT_WIDTH expression.
- Sub-module decimator_ctrl:
  - Contains the phase FSM, pending flag, out_valid, load and src_ready generation.
  - Outputs: shift_e, shift_o, load.
  - The datapath (delay lines, MAC, out register) stays in decimator.

Test Plan:
- Reset then idle -> dst_valid_out=0, dst_data_out=0, src_ready_out=1 each cycle.
- N_COEFFS=4, h=[1,2,3,4], x=1,2,3,4 back-to-back, dst_ready_in=1 -> outputs 4 then 20; first valid 2 cycles after x=2 accepted; src_ready_out never drops.
- Same setup, impulse x=0,1,0,0,0,0 -> outputs 1, 3, 0.
- Backpressure: dst_ready_in=0 for 6 cycles with continuous input -> y0 held stable; after the next odd sample, src_ready_out=0 until dst_ready_in=1; no sample lost or duplicated versus the golden model.
- bypass=1, src_data_in=16'h8001, DATA/COEFF=16 -> dst_data_out = sign-extended 0x8001<<15; dst_valid_out and src_ready_out follow src_valid_in and dst_ready_in combinationally.
- Reset asserted after an odd sample, before output -> no output appears; next pair x=5,7 with h=[1,2,3,4] -> output 17.
